port_a_reader: RTL and testbench

Input-side companion to the PORTA direction logic: samples the five RA pads through a two-flop synchronizer and returns the PORTA read value to the core on a read strobe. Reads use the TRIS setting, the output latch and RA4 open-drain rules. Also provides synchronized rising/falling edge pulses on RA4 for the TMR0 external clock (T0CKI) path. Sits between the pad models and the file-register read mux.

---
 rtl/port_a_reader.sv | 132 +++++++++++++
 tb/tb_port_a_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/port_a_reader.sv
// PORTA input path: pad synchronizer, TRIS/latch/open-drain read mux and RA4 (T0CKI) edge pulses.
// Optional build macro PORTA_RA4_FILTER_EN adds a Schmitt-trigger style filter on RA4.
module port_a_reader #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ra0,
    input  logic       ra1,
    input  logic       ra2,
    input  logic       ra3,
    input  logic       ra4,
    input  logic [4:0] tris_val,
    input  logic [4:0] lat_val,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [4:0] pin_sync,
    output logic       t0cki_rise,
    output logic       t0cki_fall
);

    localparam int unsigned NPIN     = 5;
    localparam int unsigned RD_W     = 8;
    localparam int unsigned ARM_W    = 2;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

    logic [NPIN-1:0] sync_q [SYNC_STAGES];
    logic [NPIN-1:0] pads_c;
    logic [NPIN-1:0] rd_value_c;
    logic            ra4_src_c;
    logic            prev_q;
    logic [ARM_W-1:0] arm_cnt_q;
    logic            armed_q;

    assign pads_c   = {ra4, ra3, ra2, ra1, ra0};
    assign pin_sync = sync_q[SYNC_STAGES-1];

    // Pad synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pads_c;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Read mux: RA0-3 push-pull, RA4 open drain (latch 1 lets the pad level through)
    always_comb begin
        rd_value_c = lat_val;
        for (int unsigned i = 0; i < NPIN - 1; i++) begin
            if (tris_val[i]) begin
                rd_value_c[i] = pin_sync[i];
            end
        end
        rd_value_c[NPIN-1] = (tris_val[NPIN-1] || lat_val[NPIN-1]) ? pin_sync[NPIN-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= RD_W'(rd_value_c);
            end
        end
    end

`ifdef PORTA_RA4_FILTER_EN
    logic       filt_q;
    logic       filt_d_c;
    logic [1:0] mis_cnt_q;

    // Filter follows the pad directly until armed so a high pad at reset release is not an edge
    always_comb begin
        filt_d_c = filt_q;
        if (!armed_q) begin
            filt_d_c = pin_sync[NPIN-1];
        end else if ((pin_sync[NPIN-1] != filt_q) && (mis_cnt_q == 2'd2)) begin
            filt_d_c = ~filt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q    <= 1'b0;
            mis_cnt_q <= '0;
        end else begin
            filt_q <= filt_d_c;
            if (!armed_q || (pin_sync[NPIN-1] == filt_q) || (mis_cnt_q == 2'd2)) begin
                mis_cnt_q <= '0;
            end else begin
                mis_cnt_q <= mis_cnt_q + 2'd1;
            end
        end
    end

    assign ra4_src_c = filt_d_c;
`else
    assign ra4_src_c = pin_sync[NPIN-1];
`endif

    // RA4 edge detector, gated until the synchronizer has refilled after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= 1'b0;
            t0cki_rise <= 1'b0;
            t0cki_fall <= 1'b0;
            arm_cnt_q  <= '0;
            armed_q    <= 1'b0;
        end else begin
            prev_q     <= ra4_src_c;
            t0cki_rise <= armed_q && ra4_src_c && !prev_q;
            t0cki_fall <= armed_q && !ra4_src_c && prev_q;
            if (!armed_q) begin
                if (arm_cnt_q == ARM_LAST) begin
                    armed_q <= 1'b1;
                end else begin
                    arm_cnt_q <= arm_cnt_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_port_a_reader.sv
// Bench for port_a_reader: directed scenarios plus randomized traffic against a sample-history model.
module tb_port_a_reader;

    localparam int unsigned S = 2;
`ifdef PORTA_RA4_FILTER_EN
    localparam int EDGE_LAT = 4;
`else
    localparam int EDGE_LAT = 2;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] pads;
    logic [4:0] tris_val;
    logic [4:0] lat_val;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] pin_sync;
    logic       t0cki_rise;
    logic       t0cki_fall;

    int passed = 0;
    int total  = 0;

    port_a_reader #(.SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .ra0        (pads[0]),
        .ra1        (pads[1]),
        .ra2        (pads[2]),
        .ra3        (pads[3]),
        .ra4        (pads[4]),
        .tris_val   (tris_val),
        .lat_val    (lat_val),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .pin_sync   (pin_sync),
        .t0cki_rise (t0cki_rise),
        .t0cki_fall (t0cki_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: pin_sync is the pad sample from S-1 edges ago; edges are level changes after arming
    logic [4:0] m_q[$];
    logic       m_hist[$];
    int         m_n;
    logic       m_lv, m_fl;
    logic [4:0] m_ps;
    logic [7:0] m_rd;
    logic       m_valid, m_rise, m_fall;
    bit         seen_reset = 0;
    logic [4:0] ps_pre;
    logic [4:0] rv;
    logic       lv_new;

    always @(posedge clk) begin
        if (rst) begin
            seen_reset = 1;
            m_q.delete();
            m_hist.delete();
            m_n = 0; m_lv = 0; m_fl = 0; m_ps = 0;
            m_rd = 0; m_valid = 0; m_rise = 0; m_fall = 0;
        end else begin
            ps_pre = m_ps;
            m_n++;
            m_q.push_back(pads);
            if (m_q.size() > S) void'(m_q.pop_front());
            m_ps = (m_q.size() == S) ? m_q[0] : 5'd0;
            m_hist.push_back(ps_pre[4]);
            if (m_hist.size() > 3) void'(m_hist.pop_front());
`ifdef PORTA_RA4_FILTER_EN
            if (m_n <= int'(S) + 1) m_fl = ps_pre[4];
            else if (m_hist.size() == 3 && m_hist[0] != m_fl && m_hist[1] != m_fl && m_hist[2] != m_fl)
                m_fl = ~m_fl;
            lv_new = m_fl;
`else
            lv_new = ps_pre[4];
`endif
            m_rise = (m_n >= int'(S) + 2) && lv_new && !m_lv;
            m_fall = (m_n >= int'(S) + 2) && !lv_new && m_lv;
            m_lv = lv_new;
            m_valid = rd_en;
            if (rd_en) begin
                for (int i = 0; i < 4; i++) rv[i] = tris_val[i] ? ps_pre[i] : lat_val[i];
                rv[4] = (tris_val[4] || lat_val[4]) ? ps_pre[4] : 1'b0;
                m_rd = {3'b000, rv};
            end
        end
        #1;
        if (seen_reset) begin
            chk("m_pin_sync", pin_sync, m_ps);
            chk("m_rd_data", rd_data, m_rd);
            chk("m_rd_valid", rd_valid, m_valid);
            chk("m_rise", t0cki_rise, m_rise);
            chk("m_fall", t0cki_fall, m_fall);
            chk("m_rise_fall_excl", t0cki_rise & t0cki_fall, 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic count_pulses(input int n, output int r, output int f);
        r = 0; f = 0;
        repeat (n) begin
            @(negedge clk);
            r += int'(t0cki_rise);
            f += int'(t0cki_fall);
        end
    endtask

    // Drive RA4 to lvl and check the pulse appears exactly EDGE_LAT edges later
    task automatic ra4_step(input logic lvl, input string name);
        int r, f;
        pads[4] = lvl;
        r = 0; f = 0;
        for (int d = 0; d <= EDGE_LAT + 1; d++) begin
            @(negedge clk);
            chk(name, lvl ? int'(t0cki_rise) : int'(t0cki_fall), int'(d == EDGE_LAT));
            r += int'(t0cki_rise);
            f += int'(t0cki_fall);
        end
        for (int d = 0; d < 8; d++) begin
            @(negedge clk);
            r += int'(t0cki_rise);
            f += int'(t0cki_fall);
        end
        chk({name, "_rise_cnt"}, r, int'(lvl));
        chk({name, "_fall_cnt"}, f, int'(!lvl));
    endtask

    initial begin
        int r, f, hold;
        rst = 1'b1; pads = 5'h1F; tris_val = 5'h00; lat_val = 5'h00; rd_en = 1'b0;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ps0", pin_sync, 8'h00);
        chk("rel_rd_data", rd_data, 8'h00);
        chk("rel_rd_valid", rd_valid, 0);
        @(negedge clk);
        chk("rel_ps1", pin_sync, 8'h1F);
        count_pulses(10, r, f);
        chk("rel_no_rise", r, 0);
        chk("rel_no_fall", f, 0);

        tris_val = 5'h1F; pads = 5'h15;
        cyc(3);
        do_read();
        chk("in_rd_data", rd_data, 8'h15);
        chk("in_rd_valid", rd_valid, 1);
        @(negedge clk);
        chk("in_valid_drop", rd_valid, 0);
        cyc(4);
        chk("in_hold", rd_data, 8'h15);

        tris_val = 5'h00; lat_val = 5'h0A; pads = 5'h05;
        cyc(3);
        do_read();
        chk("out_lat", rd_data, 8'h0A);
        lat_val = 5'h1A; pads = 5'h15;
        cyc(3);
        do_read();
        chk("od_high", rd_data, 8'h1A);
        pads = 5'h05;
        cyc(3);
        do_read();
        chk("od_low", rd_data, 8'h0A);

        pads = 5'h00;
        cyc(10);
        ra4_step(1'b1, "tog_rise");
        ra4_step(1'b0, "tog_fall");

`ifdef PORTA_RA4_FILTER_EN
        pads[4] = 1'b1;
        cyc(2);
        pads[4] = 1'b0;
        count_pulses(12, r, f);
        chk("filt_short_rise", r, 0);
        chk("filt_short_fall", f, 0);
        pads[4] = 1'b1;
        count_pulses(4, r, f);
        hold = r;
        pads[4] = 1'b0;
        count_pulses(12, r, f);
        chk("filt_long_rise", r + hold, 1);
        chk("filt_long_fall", f, 1);
`endif

        tris_val = 5'h1F; pads = 5'h1F;
        cyc(3);
        rst = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 8'h00);

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            rd_en = ($urandom_range(2) == 0);
            if ($urandom_range(7) == 0) tris_val = 5'($urandom);
            if ($urandom_range(7) == 0) lat_val = 5'($urandom);
            if ($urandom_range(3) == 0) pads[3:0] = 4'($urandom);
            if (hold == 0) begin
                pads[4] = ~pads[4];
                hold = $urandom_range(7, 1);
            end
            hold--;
            rst = ($urandom_range(499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; rd_en = 1'b0;
        cyc(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
